// File: rtl/swap_sequencer.sv
// swap_sequencer: command stage ahead of a swap-capable register file.
// Requests (register pair A/B) are queued in a small FIFO, validated, and then
// issued one at a time: addresses held, a single swap pulse, stall for the
// swap duration, then a done pulse. CPU writes are gated while stalled.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake; ready depends only on FIFO fill
//   req_a_i, req_b_i         register pair to exchange
//   addr_a_o, addr_b_o       register file Addr_A / Addr_B
//   swap_o                   one-cycle swap start pulse
//   cpu_we_i, cpu_we_o       CPU write enable in, gated write enable out
//   stall_o                  high while a swap is in flight
//   done_o, err_o            one-cycle completion / rejection pulses
//   swap_cnt_o               saturating count of completed swaps
module swap_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SWAP_LAT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [4:0]       req_a_i,
  input  logic [4:0]       req_b_i,
  output logic [4:0]       addr_a_o,
  output logic [4:0]       addr_b_o,
  output logic             swap_o,
  input  logic             cpu_we_i,
  output logic             cpu_we_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] swap_cnt_o
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FillW = $clog2(DEPTH + 1);
  localparam int unsigned LatW  = (SWAP_LAT > 1) ? $clog2(SWAP_LAT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [LatW-1:0]   wait_q, wait_d;
  logic [4:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic              swap_q, swap_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [9:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0]  fill_q, fill_d;
  logic              full, empty, push, pop;
  logic [4:0]        head_a, head_b;

  assign full   = (fill_q == FillW'(DEPTH));
  assign empty  = (fill_q == '0);
  assign push   = req_valid_i && !full;
  assign head_a = mem_q[rd_ptr_q][9:5];
  assign head_b = mem_q[rd_ptr_q][4:0];

  always_comb begin
    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + FillW'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - FillW'(1);
    end
  end

  // FIFO storage needs no reset; fill count alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_a_i, req_b_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fill_q <= fill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    err_d    = 1'b0;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          addr_a_d = head_a;
          addr_b_d = head_b;
          // r0 is the swap temporary, so it can never be a swap operand.
          if ((head_a == head_b) || (head_a == '0) || (head_b == '0)) begin
            err_d = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        wait_d  = LatW'(SWAP_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == '0) begin
          state_d = StDone;
        end else begin
          wait_d = wait_q - LatW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Pulses are registered from the next state so they align with it.
    swap_d = (state_d == StIssue);
    done_d = (state_d == StDone);
    cnt_d  = cnt_q;
    if ((state_d == StDone) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      swap_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      swap_q   <= swap_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready_o = !full;
  assign addr_a_o    = addr_a_q;
  assign addr_b_o    = addr_b_q;
  assign swap_o      = swap_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign swap_cnt_o  = cnt_q;
  assign stall_o     = (state_q == StIssue) || (state_q == StWait);
  assign cpu_we_o    = cpu_we_i && !stall_o;

endmodule

// File: tb/tb_swap_sequencer.sv
module tb_swap_sequencer;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned SWAP_LAT = 3;
  localparam int unsigned CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [4:0]       req_a, req_b, addr_a, addr_b;
  logic             swap, cpu_we_in, cpu_we_out, stall, done, err;
  logic [CNT_W-1:0] swap_cnt;

  always #5 clk = ~clk;

  swap_sequencer #(
    .DEPTH    (DEPTH),
    .SWAP_LAT (SWAP_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .addr_a_o    (addr_a),
    .addr_b_o    (addr_b),
    .swap_o      (swap),
    .cpu_we_i    (cpu_we_in),
    .cpu_we_o    (cpu_we_out),
    .stall_o     (stall),
    .done_o      (done),
    .err_o       (err),
    .swap_cnt_o  (swap_cnt)
  );

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    bit         exp_err;
    bit         exp_blocked;
    bit         wait_before;
  } vec_t;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    bit         is_err;
  } sb_t;

  sb_t        sb[$];
  int         tests = 0;
  int         fails = 0;
  int         since = -1;
  int         model_cnt = 0;
  logic [4:0] cur_a = '0, cur_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        since     = -1;
        model_cnt = 0;
      end else begin
        if (swap) begin
          check("swap_overlap", (since < 0), 1);
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL swap_unexpected: got swap expected none at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("swap_kind", e.is_err, 0);
            check("swap_addr_a", addr_a, e.a);
            check("swap_addr_b", addr_b, e.b);
            cur_a = e.a;
            cur_b = e.b;
          end
          since = 0;
        end else if (since >= 0) begin
          since++;
        end
        check("stall", stall, (since >= 0 && since <= int'(SWAP_LAT)));
        check("done", done, (since == int'(SWAP_LAT) + 1));
        if (since >= 0) begin
          check("hold_addr_a", addr_a, cur_a);
          check("hold_addr_b", addr_b, cur_b);
        end
        if (since == int'(SWAP_LAT) + 1) begin
          if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
          since = -1;
        end
        if (err) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL err_unexpected: got err expected none at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("err_kind", e.is_err, 1);
            check("err_addr_a", addr_a, e.a);
            check("err_addr_b", addr_b, e.b);
          end
        end
        check("cpu_we_out", cpu_we_out, cpu_we_in && !(since >= 0 && since <= int'(SWAP_LAT)));
        check("swap_cnt", swap_cnt, model_cnt);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [4:0] a, input logic [4:0] b, input bit is_err,
                      output bit blocked);
    int  guard = 0;
    sb_t e;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    #1;
    blocked = !req_ready;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: got ready 0 expected 1 at %0t", $time);
    end else begin
      e.a = a; e.b = b; e.is_err = is_err;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_quiet();
    int guard = 0;
    req_valid = 1'b0;
    while (!(sb.size() == 0 && since < 0) && guard < 300) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 300) begin
      tests++; fails++;
      $display("FAIL quiet_timeout: got pending %0d expected 0 at %0t", sb.size(), $time);
    end
    @(negedge clk);
  endtask

  vec_t vecs[9];
  bit   blk;
  int   pulses;
  sb_t  tmp;

  initial begin
    vecs[0] = '{5'd1,  5'd2,  1'b0, 1'b0, 1'b1};
    vecs[1] = '{5'd3,  5'd4,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd5,  5'd6,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd7,  5'd8,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd9,  5'd10, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5'd11, 5'd12, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{5'd4,  5'd4,  1'b1, 1'b0, 1'b1};
    vecs[7] = '{5'd0,  5'd9,  1'b1, 1'b0, 1'b0};
    vecs[8] = '{5'd2,  5'd6,  1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; cpu_we_in = 1'b0;
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_swap", swap, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", swap_cnt, 0);
    check("rst_addr_a", addr_a, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_we0", cpu_we_out, 0);
    cpu_we_in = 1'b1;
    #1;
    check("rst_we1", cpu_we_out, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single request latency: accept, pop, then swap.
    req_a = 5'd3; req_b = 5'd7; req_valid = 1'b1;
    tmp.a = 5'd3; tmp.b = 5'd7; tmp.is_err = 1'b0;
    sb.push_back(tmp);
    @(negedge clk);
    req_valid = 1'b0;
    check("lat_pop_cycle", swap, 0);
    @(negedge clk);
    check("lat_swap", swap, 1);
    check("lat_addr_a", addr_a, 3);
    check("lat_addr_b", addr_b, 7);
    wait_quiet();
    check("single_cnt", swap_cnt, 1);

    // Back-to-back fill and invalid-request table.
    foreach (vecs[i]) begin
      if (vecs[i].wait_before) wait_quiet();
      send(vecs[i].a, vecs[i].b, vecs[i].exp_err, blk);
      check($sformatf("blocked_%0d", i), blk, vecs[i].exp_blocked);
    end
    wait_quiet();
    check("table_cnt", swap_cnt, 8);

    // Reset in the middle of a swap with entries still queued.
    send(5'd5, 5'd9, 1'b0, blk);
    send(5'd6, 5'd10, 1'b0, blk);
    send(5'd7, 5'd11, 1'b0, blk);
    req_valid = 1'b0;
    begin
      int guard = 0;
      while (since != 2 && guard < 50) begin
        @(negedge clk);
        #1;
        guard++;
      end
      check("reach_wait", since, 2);
    end
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_swap", swap, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_cnt", swap_cnt, 0);
    check("mid_rst_addr_a", addr_a, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (swap || done || err) pulses++;
    end
    check("post_rst_pulses", pulses, 0);
    check("post_rst_ready", req_ready, 1);

    // Saturation of the completed-swap counter.
    for (int i = 0; i < 16; i++) begin
      cpu_we_in = 1'($urandom_range(0, 1));
      send(5'(1 + (i % 30)), 5'(2 + (i % 30)), 1'b0, blk);
    end
    wait_quiet();
    check("sat_cnt", swap_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/swap_sequencer.md
Name: swap_sequencer

Overview:
- Upstream command stage for the swap-capable register file. Queues swap requests (register pair A/B) in a small FIFO and validates each one.
- Drives the register file's Addr_A/Addr_B/swap inputs one swap at a time, holding addresses stable for the full swap duration.
- Gates CPU register writes and raises a stall while a swap is in flight, so normal writeback never collides with the swap's internal write cycles.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
SWAP_LAT, 3, cycles the downstream register file needs after the swap pulse before addresses may change (>=1)
CNT_W, 16, width of completed-swap counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  swap request valid
req_ready  out  1  FIFO can accept a request
req_a  in  5  first register index
req_b  in  5  second register index
addr_a  out  5  to register file Addr_A
addr_b  out  5  to register file Addr_B
swap  out  1  one-cycle swap start pulse to register file
cpu_we_in  in  1  CPU register write enable
cpu_we_out  out  1  gated write enable to register file WE
stall  out  1  pipeline stall while swap in flight
done  out  1  one-cycle pulse, swap completed
err  out  1  one-cycle pulse, request rejected
swap_cnt  out  CNT_W  completed swaps, saturating

Behaviour:
- Reset (rst=0, async): FIFO flushed (pointers/count 0), state IDLE, addr_a=addr_b=0, swap=0, stall=0, done=0, err=0, swap_cnt=0. cpu_we_out=cpu_we_in (stall=0). Reset mid-swap aborts immediately; no done pulse.
- FIFO: push on req_valid&&req_ready; req_ready = !full (no combinational dependence on pop). Push and pop in the same cycle are legal; count unchanged. No bypass: an entry pushed at edge t is poppable at edge t+1 at the earliest. req_valid while full is ignored (no push, no err).
- FSM states IDLE, ISSUE, WAIT, DONE.
- IDLE: if FIFO non-empty, pop head and register it into addr_a/addr_b.
  - If head invalid (a==b, or a==0, or b==0; r0 is the swap temp), pulse err next cycle and stay IDLE. addr regs are still loaded.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): swap=1, stall=1, load wait counter with SWAP_LAT-1, go to WAIT.
- WAIT: stall=1, counter decrements each cycle. At 0, go to DONE. Total cycles with stall=1 = SWAP_LAT+1 (ISSUE plus SWAP_LAT WAIT cycles, counter SWAP_LAT-1 down to 0).
- DONE (1 cycle): done=1, stall=0, swap_cnt+=1 (holds at all-ones), go to IDLE.
- addr_a/addr_b change only on an IDLE pop and are otherwise held, including through DONE.
- swap, done, err are registered (Moore) outputs. stall is high in exactly ISSUE and WAIT.
- cpu_we_out = cpu_we_in & !stall (combinational). Writes attempted during stall are dropped; upstream holds them via stall.
- Latency with FIFO empty and IDLE: request accepted at edge t → popped edge t+1 → swap high in cycle after t+1 → done high SWAP_LAT+1 cycles after swap.
- Back-to-back: the next pop happens in the IDLE cycle after DONE, so minimum spacing between swap pulses is SWAP_LAT+3 cycles.
- An invalid entry costs one IDLE cycle. A following valid entry pops in the next cycle.

Test Plan:
- Reset then single request a=3,b=7 → swap pulses once with addr_a=3, addr_b=7; stall high 4 cycles; done pulses 1 cycle later; swap_cnt=1; RF shows r3/r7 exchanged.
- Push 5 requests back-to-back with DEPTH=4 and no pops possible yet → req_ready drops after 4th accepted entry; 5th held until a pop; all 5 swaps execute in order; swap_cnt=5.
- Requests (4,4), (0,9), (2,6) → err pulses twice with no swap pulse; then one swap 2↔6; swap_cnt=1.
- cpu_we_in=1 held throughout a swap → cpu_we_out=0 exactly while stall=1, 1 otherwise; no RF write corruption.
- Drive rst low during WAIT → swap/stall/done/err/swap_cnt=0 immediately; FIFO empty; req_ready=1 after release; no done pulse.
- Force swap_cnt to all-ones (CNT_W=4, 15 swaps) then one more swap → counter stays 15.
